sram_dual_ctrl: RTL

//  Downstream of the RAM test state machine: turns single-cycle re/we requests on a
//  17-bit address into timed accesses on the two board SRAMs (RAM1/RAM2).

---
 rtl/sram_dual_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_dual_ctrl.sv
// Dual-bank asynchronous SRAM access controller: turns single-cycle re/we requests
// into timed EN#/OE#/WE# sequences on RAM1/RAM2 and returns read data with a done pulse.
module sram_dual_ctrl #(
  parameter int unsigned WR_PULSE_CYC = 1,
  parameter int unsigned RD_WAIT_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        busy,
  output logic [17:0] ram_addr1,
  inout  wire  [15:0] ram_data1,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic [17:0] ram_addr2,
  inout  wire  [15:0] ram_data2,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE
);

  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RAM_AW  = 18;
  localparam int unsigned MAX_CYC = (WR_PULSE_CYC > RD_WAIT_CYC) ? WR_PULSE_CYC : RD_WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_WAIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [RAM_AW-1:0]   ram_addr1_q, ram_addr1_d, ram_addr2_q, ram_addr2_d;
  logic                en1_n_q, en1_n_d, oe1_n_q, oe1_n_d, we1_n_q, we1_n_d, drv1_q, drv1_d;
  logic                en2_n_q, en2_n_d, oe2_n_q, oe2_n_d, we2_n_q, we2_n_d, drv2_q, drv2_d;

  // Bank-agnostic strobes for the state being entered, steered to one bank below
  logic                acc_en_n, acc_oe_n, acc_we_n, acc_drv, sel2;
  logic [DATA_W-1:0]   rd_data;

  assign rd_data = addr_q[16] ? ram_data2 : ram_data1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    acc_en_n   = 1'b1;
    acc_oe_n   = 1'b1;
    acc_we_n   = 1'b1;
    acc_drv    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && we) begin
          addr_d   = addr;
          wdata_d  = data_in;
          state_d  = WR_SETUP;
          acc_en_n = 1'b0;
          acc_drv  = 1'b1;
        end else if (en && re) begin
          addr_d   = addr;
          cnt_d    = RD_LAST;
          state_d  = RD_WAIT;
          acc_en_n = 1'b0;
          acc_oe_n = 1'b0;
        end
      end
      WR_SETUP: begin
        cnt_d    = WR_LAST;
        state_d  = WR_PULSE;
        acc_en_n = 1'b0;
        acc_we_n = 1'b0;
        acc_drv  = 1'b1;
      end
      WR_PULSE: begin
        acc_en_n = 1'b0;
        acc_drv  = 1'b1;
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          acc_we_n = 1'b0;
        end
      end
      WR_HOLD: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          data_out_d = rd_data;
          state_d    = DONE;
          done_d     = 1'b1;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          acc_en_n = 1'b0;
          acc_oe_n = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Only the bank addressed by addr[16] sees strobes, address and drive
    sel2        = addr_d[16];
    ram_addr1_d = (!acc_en_n && !sel2) ? {2'b00, addr_d[15:0]} : '0;
    ram_addr2_d = (!acc_en_n &&  sel2) ? {2'b00, addr_d[15:0]} : '0;
    en1_n_d     = acc_en_n | sel2;
    oe1_n_d     = acc_oe_n | sel2;
    we1_n_d     = acc_we_n | sel2;
    drv1_d      = acc_drv & ~sel2;
    en2_n_d     = acc_en_n | ~sel2;
    oe2_n_d     = acc_oe_n | ~sel2;
    we2_n_d     = acc_we_n | ~sel2;
    drv2_d      = acc_drv & sel2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr1_q <= '0;
      ram_addr2_q <= '0;
      en1_n_q     <= 1'b1;
      oe1_n_q     <= 1'b1;
      we1_n_q     <= 1'b1;
      drv1_q      <= 1'b0;
      en2_n_q     <= 1'b1;
      oe2_n_q     <= 1'b1;
      we2_n_q     <= 1'b1;
      drv2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ram_addr1_q <= ram_addr1_d;
      ram_addr2_q <= ram_addr2_d;
      en1_n_q     <= en1_n_d;
      oe1_n_q     <= oe1_n_d;
      we1_n_q     <= we1_n_d;
      drv1_q      <= drv1_d;
      en2_n_q     <= en2_n_d;
      oe2_n_q     <= oe2_n_d;
      we2_n_q     <= we2_n_d;
      drv2_q      <= drv2_d;
    end
  end

  assign data_out  = data_out_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign ram_addr1 = ram_addr1_q;
  assign ram_addr2 = ram_addr2_q;
  assign ram1EN    = en1_n_q;
  assign ram1OE    = oe1_n_q;
  assign ram1WE    = we1_n_q;
  assign ram2EN    = en2_n_q;
  assign ram2OE    = oe2_n_q;
  assign ram2WE    = we2_n_q;
  assign ram_data1 = drv1_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_data2 = drv2_q ? wdata_q : {DATA_W{1'bz}};

endmodule
